ifm_pingpong_buffer: RTL and testbench

Double-buffered IFM storage between a pooling layer (writer) and the following convolution layer (reader). Accepts pixel writes tagged with an output-map select from the pool block, and hands complete frames to the conv block through a two-bank ping-pong scheme. Provides the two read ports (A/B) the conv block uses. Exchanges start/end pulses with both neighbours.

---
 rtl/ifm_buf_pkg.sv | 32 +++
 rtl/ifm_pingpong_buffer_bank_ram.sv | 49 ++++
 rtl/ifm_pingpong_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_ifm_pingpong_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_buf_pkg.sv
// ifm_buf_pkg: shared types and sizing helpers for the IFM ping-pong buffer.
//   - rd_state_e : reader handshake state (R_IDLE / R_BUSY)
//   - rd_src_e   : which source drives a registered read port
//   - bank_depth : words per bank (maps per unit * map edge squared)
//   - width_of   : address width for a given word count (never below 1)
package ifm_buf_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_e;

  // A read port remembers where its last accepted read came from, so the
  // output holds while its enable is low and reads as zero after an
  // out-of-range address.
  typedef enum logic [1:0] {
    SRC_ZERO  = 2'd0,
    SRC_BANK0 = 2'd1,
    SRC_BANK1 = 2'd2
  } rd_src_e;

  function automatic int unsigned bank_depth(input int unsigned depth,
                                             input int unsigned units,
                                             input int unsigned size);
    return (depth / units) * size * size;
  endfunction

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/ifm_pingpong_buffer_bank_ram.sv
// ifm_bank_ram: one storage bank of the ping-pong buffer.
//   clk                 rising-edge clock
//   we_i/waddr_i/wdata_i  single synchronous write port
//   re_a_i/raddr_a_i    read port A strobe/address -> rdata_a_o one cycle later
//   re_b_i/raddr_b_i    read port B strobe/address -> rdata_b_o one cycle later
// The array has no reset; read registers hold when their strobe is low.
// A read of a word written in the same cycle returns the previous contents.
module ifm_bank_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 400,
  parameter int unsigned AW         = 9
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_a_i,
  input  logic [AW-1:0]         raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic                  re_b_i,
  input  logic [AW-1:0]         raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;

  // Write port: the caller guarantees waddr_i is inside the bank.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: registered, updated only on their strobe.
  always_ff @(posedge clk) begin
    if (re_a_i) begin
      rdata_a_q <= mem_q[raddr_a_i];
    end
    if (re_b_i) begin
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// ifm_pingpong_buffer: two-bank IFM store between a pooling writer and a
// convolution reader.
//   Writer side : start_from_previous, ifm_enable_write, ifm_address_write,
//                 ifm_sel_write, data_in -> conv_ready, end_to_previous
//   Reader side : end_from_next, ifm_enable_read_A/B, ifm_address_read_A/B,
//                 ifm_sel_read -> start_to_next, data_out_A/B
//   overflow    : sticky, set by a write or frame-end hitting a full bank
// The writer fills wr_bank; a frame-end marks it full and flips wr_bank.
// The reader is offered rd_bank once it is full and releases it with
// end_from_next, which clears the flag and flips rd_bank.
module ifm_pingpong_buffer
  import ifm_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned IFM_SIZE         = 5,
  parameter int unsigned IFM_DEPTH        = 16,
  parameter int unsigned NUMBER_OF_UNITS  = 1,
  parameter int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int unsigned SEL_WIDTH        = $clog2(IFM_DEPTH / NUMBER_OF_UNITS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_from_previous,
  input  logic                        ifm_enable_write,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write,
  input  logic [SEL_WIDTH-1:0]        ifm_sel_write,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        conv_ready,
  output logic                        end_to_previous,
  output logic                        start_to_next,
  input  logic                        end_from_next,
  input  logic                        ifm_enable_read_A,
  input  logic                        ifm_enable_read_B,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B,
  input  logic [SEL_WIDTH-1:0]        ifm_sel_read,
  output logic [DATA_WIDTH-1:0]       data_out_A,
  output logic [DATA_WIDTH-1:0]       data_out_B,
  output logic                        overflow
);

  localparam int unsigned MAPS       = IFM_DEPTH / NUMBER_OF_UNITS;
  localparam int unsigned MAP_WORDS  = IFM_SIZE * IFM_SIZE;
  localparam int unsigned BANK_WORDS = bank_depth(IFM_DEPTH, NUMBER_OF_UNITS, IFM_SIZE);
  localparam int unsigned BANK_AW    = width_of(BANK_WORDS);

  function automatic logic [BANK_AW-1:0] word_index(input logic [SEL_WIDTH-1:0]        sel,
                                                    input logic [ADDRESS_SIZE_IFM-1:0] addr);
    return BANK_AW'(32'(sel) * MAP_WORDS + 32'(addr));
  endfunction

  rd_state_e   state_q;
  logic [1:0]  full_q, full_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        overflow_q, overflow_d;
  logic        start_to_next_q;
  logic        end_to_previous_q;
  rd_src_e     src_a_q, src_b_q;

  logic                  wr_in_range_s;
  logic                  wr_accept_s;
  logic                  release_s;
  logic                  rd_ok_a_s, rd_ok_b_s;
  rd_src_e               src_a_s, src_b_s;
  logic [BANK_AW-1:0]    widx_s, ridx_a_s, ridx_b_s;
  logic [1:0]            we_s, re_a_s, re_b_s;
  logic [DATA_WIDTH-1:0] rdata_a_s [2];
  logic [DATA_WIDTH-1:0] rdata_b_s [2];

  assign wr_in_range_s = (32'(ifm_address_write) < MAP_WORDS) && (32'(ifm_sel_write) < MAPS);
  assign wr_accept_s   = ifm_enable_write && !full_q[wr_bank_q] && wr_in_range_s;
  assign release_s     = (state_q == R_BUSY) && end_from_next;
  assign widx_s        = word_index(ifm_sel_write, ifm_address_write);
  assign we_s          = {wr_accept_s && wr_bank_q, wr_accept_s && !wr_bank_q};

  assign rd_ok_a_s = (32'(ifm_address_read_A) < MAP_WORDS) && (32'(ifm_sel_read) < MAPS);
  assign rd_ok_b_s = (32'(ifm_address_read_B) < MAP_WORDS) && (32'(ifm_sel_read) < MAPS);
  assign ridx_a_s  = word_index(ifm_sel_read, ifm_address_read_A);
  assign ridx_b_s  = word_index(ifm_sel_read, ifm_address_read_B);
  assign re_a_s    = {ifm_enable_read_A && rd_ok_a_s && rd_bank_q,
                      ifm_enable_read_A && rd_ok_a_s && !rd_bank_q};
  assign re_b_s    = {ifm_enable_read_B && rd_ok_b_s && rd_bank_q,
                      ifm_enable_read_B && rd_ok_b_s && !rd_bank_q};
  assign src_a_s   = !rd_ok_a_s ? SRC_ZERO : (rd_bank_q ? SRC_BANK1 : SRC_BANK0);
  assign src_b_s   = !rd_ok_b_s ? SRC_ZERO : (rd_bank_q ? SRC_BANK1 : SRC_BANK0);

  // Next full flags, bank pointers and overflow. Writer frame-end and reader
  // release touch different banks, so both may apply in one cycle.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q;
    if (ifm_enable_write && full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
    if (start_from_previous) begin
      if (!full_q[wr_bank_q]) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end
  end

  // Bank state and reader FSM. R_IDLE looks at the next-state full flag so
  // start_to_next follows a frame-end by exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= R_IDLE;
      full_q            <= 2'b00;
      wr_bank_q         <= 1'b0;
      rd_bank_q         <= 1'b0;
      overflow_q        <= 1'b0;
      start_to_next_q   <= 1'b0;
      end_to_previous_q <= 1'b0;
    end else begin
      full_q            <= full_d;
      wr_bank_q         <= wr_bank_d;
      rd_bank_q         <= rd_bank_d;
      overflow_q        <= overflow_d;
      start_to_next_q   <= 1'b0;
      end_to_previous_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (full_d[rd_bank_q]) begin
            start_to_next_q <= 1'b1;
            state_q         <= R_BUSY;
          end
        end
        R_BUSY: begin
          if (end_from_next) begin
            end_to_previous_q <= 1'b1;
            state_q           <= R_IDLE;
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  // Read-port source selects; captured with the RAM read so outputs hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_a_q <= SRC_ZERO;
      src_b_q <= SRC_ZERO;
    end else begin
      if (ifm_enable_read_A) begin
        src_a_q <= src_a_s;
      end
      if (ifm_enable_read_B) begin
        src_b_q <= src_b_s;
      end
    end
  end

  // Output mux over the registered RAM read data.
  always_comb begin
    data_out_A = '0;
    data_out_B = '0;
    case (src_a_q)
      SRC_BANK0: data_out_A = rdata_a_s[0];
      SRC_BANK1: data_out_A = rdata_a_s[1];
      default:   data_out_A = '0;
    endcase
    case (src_b_q)
      SRC_BANK0: data_out_B = rdata_b_s[0];
      SRC_BANK1: data_out_B = rdata_b_s[1];
      default:   data_out_B = '0;
    endcase
  end

  ifm_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BANK_WORDS),
    .AW         (BANK_AW)
  ) u_bank0 (
    .clk       (clk),
    .we_i      (we_s[0]),
    .waddr_i   (widx_s),
    .wdata_i   (data_in),
    .re_a_i    (re_a_s[0]),
    .raddr_a_i (ridx_a_s),
    .rdata_a_o (rdata_a_s[0]),
    .re_b_i    (re_b_s[0]),
    .raddr_b_i (ridx_b_s),
    .rdata_b_o (rdata_b_s[0])
  );

  ifm_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BANK_WORDS),
    .AW         (BANK_AW)
  ) u_bank1 (
    .clk       (clk),
    .we_i      (we_s[1]),
    .waddr_i   (widx_s),
    .wdata_i   (data_in),
    .re_a_i    (re_a_s[1]),
    .raddr_a_i (ridx_a_s),
    .rdata_a_o (rdata_a_s[1]),
    .re_b_i    (re_b_s[1]),
    .raddr_b_i (ridx_b_s),
    .rdata_b_o (rdata_b_s[1])
  );

  assign conv_ready      = !full_q[wr_bank_q];
  assign start_to_next   = start_to_next_q;
  assign end_to_previous = end_to_previous_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// tb_ifm_pingpong_buffer: directed handshake scenarios followed by random
// traffic, all checked every cycle against a frame-level reference model.
module tb_ifm_pingpong_buffer;

  localparam int MW = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_from_previous = 1'b0;
  logic        ifm_enable_write = 1'b0;
  logic [4:0]  ifm_address_write = 5'd0;
  logic [3:0]  ifm_sel_write = 4'd0;
  logic [31:0] data_in = 32'd0;
  logic        conv_ready;
  logic        end_to_previous;
  logic        start_to_next;
  logic        end_from_next = 1'b0;
  logic        ifm_enable_read_A = 1'b0;
  logic        ifm_enable_read_B = 1'b0;
  logic [4:0]  ifm_address_read_A = 5'd0;
  logic [4:0]  ifm_address_read_B = 5'd0;
  logic [3:0]  ifm_sel_read = 4'd0;
  logic [31:0] data_out_A;
  logic [31:0] data_out_B;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  ifm_pingpong_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .start_from_previous (start_from_previous),
    .ifm_enable_write    (ifm_enable_write),
    .ifm_address_write   (ifm_address_write),
    .ifm_sel_write       (ifm_sel_write),
    .data_in             (data_in),
    .conv_ready          (conv_ready),
    .end_to_previous     (end_to_previous),
    .start_to_next       (start_to_next),
    .end_from_next       (end_from_next),
    .ifm_enable_read_A   (ifm_enable_read_A),
    .ifm_enable_read_B   (ifm_enable_read_B),
    .ifm_address_read_A  (ifm_address_read_A),
    .ifm_address_read_B  (ifm_address_read_B),
    .ifm_sel_read        (ifm_sel_read),
    .data_out_A          (data_out_A),
    .data_out_B          (data_out_B),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: two banks of words plus frame bookkeeping.
  logic [31:0] m_mem [2][400];
  bit          m_val [2][400];
  bit [1:0]    m_full = 2'b00;
  bit          m_wr = 1'b0, m_rd = 1'b0, m_busy = 1'b0, m_ovf = 1'b0;
  logic [31:0] e_da = 32'd0, e_db = 32'd0;
  bit          e_da_k = 1'b0, e_db_k = 1'b0;
  bit          e_stn = 1'b0, e_etp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int idx;
    bit [1:0] nf;
    e_stn = 1'b0;
    e_etp = 1'b0;
    if (reset) begin
      m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
      e_da = 32'd0; e_db = 32'd0; e_da_k = 1'b1; e_db_k = 1'b1;
    end else begin
      // reads see the contents before this cycle's write
      if (ifm_enable_read_A) begin
        if (int'(ifm_address_read_A) < MW) begin
          idx = int'(ifm_sel_read) * MW + int'(ifm_address_read_A);
          e_da = m_mem[m_rd][idx]; e_da_k = m_val[m_rd][idx];
        end else begin
          e_da = 32'd0; e_da_k = 1'b1;
        end
      end
      if (ifm_enable_read_B) begin
        if (int'(ifm_address_read_B) < MW) begin
          idx = int'(ifm_sel_read) * MW + int'(ifm_address_read_B);
          e_db = m_mem[m_rd][idx]; e_db_k = m_val[m_rd][idx];
        end else begin
          e_db = 32'd0; e_db_k = 1'b1;
        end
      end
      if (ifm_enable_write) begin
        if (m_full[m_wr]) m_ovf = 1'b1;
        else if (int'(ifm_address_write) < MW) begin
          idx = int'(ifm_sel_write) * MW + int'(ifm_address_write);
          m_mem[m_wr][idx] = data_in; m_val[m_wr][idx] = 1'b1;
        end
      end
      nf = m_full;
      if (start_from_previous) begin
        if (!m_full[m_wr]) begin nf[m_wr] = 1'b1; m_wr = ~m_wr; end
        else m_ovf = 1'b1;
      end
      if (m_busy && end_from_next) begin
        nf[m_rd] = 1'b0; m_rd = ~m_rd; e_etp = 1'b1; m_busy = 1'b0;
      end else if (!m_busy && nf[m_rd]) begin
        e_stn = 1'b1; m_busy = 1'b1;
      end
      m_full = nf;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("start_to_next", 32'(start_to_next), 32'(e_stn));
    chk("end_to_previous", 32'(end_to_previous), 32'(e_etp));
    chk("conv_ready", 32'(conv_ready), 32'(!m_full[m_wr]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (e_da_k) chk("data_out_A", data_out_A, e_da);
    if (e_db_k) chk("data_out_B", data_out_B, e_db);
  endtask

  task automatic idle();
    reset = 1'b0; start_from_previous = 1'b0; end_from_next = 1'b0;
    ifm_enable_write = 1'b0; ifm_enable_read_A = 1'b0; ifm_enable_read_B = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] s, input logic [4:0] a, input logic [31:0] d);
    ifm_enable_write = 1'b1; ifm_sel_write = s; ifm_address_write = a; data_in = d;
    tick(); idle();
  endtask

  task automatic do_sfp();
    start_from_previous = 1'b1; tick(); idle();
  endtask

  task automatic do_efn();
    end_from_next = 1'b1; tick(); idle();
  endtask

  task automatic read_a(input logic [3:0] s, input logic [4:0] a);
    ifm_enable_read_A = 1'b1; ifm_sel_read = s; ifm_address_read_A = a;
    tick(); idle();
  endtask

  task automatic read_b(input logic [3:0] s, input logic [4:0] a);
    ifm_enable_read_B = 1'b1; ifm_sel_read = s; ifm_address_read_B = a;
    tick(); idle();
  endtask

  initial begin
    // reset state
    reset = 1'b1; tick(); tick();
    chk("rst_conv_ready", 32'(conv_ready), 32'd1);
    chk("rst_data_out_A", data_out_A, 32'd0);
    idle();

    // first frame: write, hand over, read back
    do_write(4'd3, 5'd7, 32'hDEADBEEF);
    do_sfp();
    chk("tp1_start_to_next", 32'(start_to_next), 32'd1);
    read_a(4'd3, 5'd7);
    chk("tp1_read_A", data_out_A, 32'hDEADBEEF);

    // fill bank 1, then overrun with both banks full
    do_write(4'd1, 5'd2, 32'h11112222);
    do_sfp();
    chk("tp2_conv_ready_low", 32'(conv_ready), 32'd0);
    do_write(4'd3, 5'd7, 32'h00000BAD);
    do_sfp();
    chk("tp2_overflow", 32'(overflow), 32'd1);
    read_a(4'd3, 5'd7);
    chk("tp2_bank0_intact", data_out_A, 32'hDEADBEEF);

    // release bank 0: end_to_previous at t+1, start_to_next at t+2
    do_efn();
    chk("tp3_end_to_previous", 32'(end_to_previous), 32'd1);
    chk("tp3_conv_ready", 32'(conv_ready), 32'd1);
    tick();
    chk("tp3_start_to_next", 32'(start_to_next), 32'd1);
    read_b(4'd1, 5'd2);
    chk("tp3_read_B_bank1", data_out_B, 32'h11112222);

    // frame-end and release in the same cycle
    do_write(4'd0, 5'd0, 32'hCAFEF00D);
    start_from_previous = 1'b1; end_from_next = 1'b1; tick(); idle();
    chk("tp4_end_to_previous", 32'(end_to_previous), 32'd1);
    tick();
    chk("tp4_start_to_next", 32'(start_to_next), 32'd1);
    chk("tp4_conv_ready", 32'(conv_ready), 32'd1);
    read_a(4'd0, 5'd0);
    chk("tp4_read_A_bank0", data_out_A, 32'hCAFEF00D);

    // out-of-range address
    reset = 1'b1; tick(); idle();
    do_write(4'd0, 5'd25, 32'h12345678);
    chk("tp5_overflow_clear", 32'(overflow), 32'd0);
    read_a(4'd0, 5'd25);
    chk("tp5_read_oob_zero", data_out_A, 32'd0);

    // reset while the reader is busy, then a fresh frame from bank 0
    do_write(4'd2, 5'd4, 32'hA5A5A5A5);
    do_sfp();
    read_b(4'd2, 5'd4);
    reset = 1'b1; tick(); idle();
    chk("tp6_rst_start_to_next", 32'(start_to_next), 32'd0);
    chk("tp6_rst_conv_ready", 32'(conv_ready), 32'd1);
    chk("tp6_rst_data_out_B", data_out_B, 32'd0);
    do_write(4'd2, 5'd4, 32'h5A5A5A5A);
    do_sfp();
    chk("tp6_start_to_next", 32'(start_to_next), 32'd1);
    read_a(4'd2, 5'd4);
    chk("tp6_read_A", data_out_A, 32'h5A5A5A5A);
    do_efn();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset               = ($urandom_range(0, 149) == 0);
      start_from_previous = ($urandom_range(0, 11) == 0);
      end_from_next       = ($urandom_range(0, 9) == 0);
      ifm_enable_write    = ($urandom_range(0, 1) == 1);
      ifm_address_write   = 5'($urandom_range(0, 31));
      ifm_sel_write       = 4'($urandom);
      data_in             = $urandom;
      ifm_enable_read_A   = ($urandom_range(0, 1) == 1);
      ifm_enable_read_B   = ($urandom_range(0, 1) == 1);
      ifm_address_read_A  = 5'($urandom_range(0, 31));
      ifm_address_read_B  = 5'($urandom_range(0, 31));
      ifm_sel_read        = 4'($urandom);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
